// File: rtl/memory_master_pkg.sv
// Shared definitions for the queued memory master: host command codes and STATUS layout.
package memory_master_pkg;

  typedef enum logic [7:0] {
    CmdNone         = 8'd0,
    CmdAddressLower = 8'd1,
    CmdAddressUpper = 8'd2,
    CmdData         = 8'd3,
    CmdMasterId     = 8'd4,
    CmdWrite        = 8'd5,
    CmdPush         = 8'd6,
    CmdPop          = 8'd7,
    CmdReadData     = 8'd8,
    CmdReadId       = 8'd9,
    CmdStatus       = 8'd10,
    CmdClearErr     = 8'd11
  } command_t;

  localparam int unsigned FieldWidth = 24;

  localparam int unsigned StatReqFull     = 0;
  localparam int unsigned StatReqEmpty    = 1;
  localparam int unsigned StatRspFull     = 2;
  localparam int unsigned StatRspEmpty    = 3;
  localparam int unsigned StatErrOvf      = 4;
  localparam int unsigned StatErrUnf      = 5;
  localparam int unsigned StatReqCountLsb = 8;
  localparam int unsigned StatRspCountLsb = 16;

endpackage

// File: rtl/memory_master_queued_if.sv
// MemoryBus master/slave signal bundle; ms* carry requests, sm* carry responses.
interface memory_master_queued_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ID_WIDTH   = 8
);
  logic [ADDR_WIDTH-1:0] msAddress;
  logic [DATA_WIDTH-1:0] msData;
  logic [ID_WIDTH-1:0]   msID;
  logic                  msWrite;
  logic                  msValid;
  logic                  msTaken;
  logic [DATA_WIDTH-1:0] smData;
  logic [ID_WIDTH-1:0]   smID;
  logic                  smValid;
  logic                  smTake;

  modport master (
    output msAddress, msData, msID, msWrite, msValid, smTake,
    input  msTaken, smData, smID, smValid
  );

  modport slave (
    input  msAddress, msData, msID, msWrite, msValid, smTake,
    output msTaken, smData, smID, smValid
  );
endinterface

// File: rtl/memory_master_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (any depth >= 2).
module memory_master_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so stale storage never reaches the outputs.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/memory_master_queued.sv
// Host command-word bridge to a queued MemoryBus master.
// Optional MEMORY_MASTER_AUTO_INC_EN: each accepted PUSH post-increments the staged address.
module memory_master_queued
  import memory_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            in,
  output logic [31:0]            out,
  memory_master_queued_if.master bus
);

`ifdef MEMORY_MASTER_AUTO_INC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  localparam int unsigned ReqCntW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RspCntW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic                  write;
  } request_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } response_t;

  logic [7:0]            cmd, cmd_q;
  logic [FieldWidth-1:0] field;
  logic                  fire;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  write_q;
  logic                  err_ovf_q, err_unf_q;
  logic                  run_q;

  request_t              req_wdata, req_head;
  response_t             rsp_wdata, rsp_head;
  logic                  req_full, req_empty, rsp_full, rsp_empty;
  logic [ReqCntW-1:0]    req_count;
  logic [RspCntW-1:0]    rsp_count;
  logic                  req_push, req_pop, rsp_push, rsp_pop;
  logic                  sm_take;

  assign cmd   = in[31:24];
  assign field = in[FieldWidth-1:0];
  assign fire  = (cmd != cmd_q) && (cmd != CmdNone);

  // Full/empty are registered, so a same-cycle dequeue never rescues a PUSH or POP.
  assign req_push = fire && (cmd == CmdPush) && !req_full;
  assign rsp_pop  = fire && (cmd == CmdPop) && !rsp_empty;
  assign req_pop  = !req_empty && bus.msTaken;
  assign sm_take  = run_q && !rsp_full;
  assign rsp_push = bus.smValid && sm_take;

  assign req_wdata = '{addr: addr_q, data: data_q, id: id_q, write: write_q};
  assign rsp_wdata = '{data: bus.smData, id: bus.smID};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q     <= CmdNone;
      addr_q    <= '0;
      data_q    <= '0;
      id_q      <= '0;
      write_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      cmd_q <= cmd;
      run_q <= 1'b1;
      if (fire) begin
        case (cmd)
          CmdAddressLower: addr_q[FieldWidth-1:0] <= field;
          CmdAddressUpper: addr_q[ADDR_WIDTH-1:FieldWidth] <= field[ADDR_WIDTH-FieldWidth-1:0];
          CmdData:         data_q  <= field[DATA_WIDTH-1:0];
          CmdMasterId:     id_q    <= field[ID_WIDTH-1:0];
          CmdWrite:        write_q <= field[0];
          CmdPush: begin
            if (req_full) err_ovf_q <= 1'b1;
            else if (AutoInc) addr_q <= addr_q + 1'b1;
          end
          CmdPop: begin
            if (rsp_empty) err_unf_q <= 1'b1;
          end
          CmdClearErr: begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  memory_master_fifo #(
    .WIDTH ($bits(request_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_push),
    .wdata (req_wdata),
    .pop   (req_pop),
    .rdata (req_head),
    .full  (req_full),
    .empty (req_empty),
    .count (req_count)
  );

  memory_master_fifo #(
    .WIDTH ($bits(response_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign bus.msValid   = !req_empty;
  assign bus.msAddress = req_head.addr;
  assign bus.msData    = req_head.data;
  assign bus.msID      = req_head.id;
  assign bus.msWrite   = req_head.write;
  assign bus.smTake    = sm_take;

  always_comb begin
    out = '0;
    case (cmd)
      CmdReadData: out = 32'(rsp_head.data);
      CmdReadId:   out = 32'(rsp_head.id);
      CmdStatus: begin
        out[StatReqFull]              = req_full;
        out[StatReqEmpty]             = req_empty;
        out[StatRspFull]              = rsp_full;
        out[StatRspEmpty]             = rsp_empty;
        out[StatErrOvf]               = err_ovf_q;
        out[StatErrUnf]               = err_unf_q;
        out[StatReqCountLsb +: 8]     = 8'(req_count);
        out[StatRspCountLsb +: 8]     = 8'(rsp_count);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_master_queued.sv
// Bench for memory_master_queued: directed vector table, reset corners, randomized traffic
// checked against a queue-based reference model.
module tb_memory_master_queued;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 24;
  localparam int unsigned IW = 8;
  localparam int unsigned RD = 4;
  localparam int unsigned SD = 4;

  localparam logic [7:0] NONE = 8'd0, ADDRL = 8'd1, ADDRU = 8'd2, DATA = 8'd3, MID = 8'd4;
  localparam logic [7:0] WRITE = 8'd5, PUSH = 8'd6, POP = 8'd7, RDATA = 8'd8, RID = 8'd9;
  localparam logic [7:0] STATUS = 8'd10, CLR = 8'd11;

  localparam logic [3:0] C_OUT = 4'b0001, C_MSV = 4'b0010, C_ADDR = 4'b0100, C_TAKE = 4'b1000;

`ifdef MEMORY_MASTER_AUTO_INC_EN
  localparam logic [31:0] SECOND_ADDR = 32'h0000_0000;
`else
  localparam logic [31:0] SECOND_ADDR = 32'hFFFF_FFFF;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] host_in = '0;
  logic [31:0] host_out;

  always #5 clock = ~clock;

  memory_master_queued_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  memory_master_queued #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .REQ_DEPTH  (RD),
    .RSP_DEPTH  (SD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .in    (host_in),
    .out   (host_out),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues of transactions plus staging state.
  typedef struct packed {
    logic [31:0] addr;
    logic [23:0] data;
    logic [7:0]  id;
    logic        wr;
  } req_t;

  typedef struct packed {
    logic [23:0] data;
    logic [7:0]  id;
  } rsp_t;

  req_t        m_req[$];
  rsp_t        m_rsp[$];
  logic [31:0] m_addr;
  logic [23:0] m_data;
  logic [7:0]  m_id;
  logic        m_write, m_ovf, m_unf, m_run;
  logic [7:0]  m_prev;

  task automatic model_reset();
    m_req.delete();
    m_rsp.delete();
    m_addr = '0; m_data = '0; m_id = '0; m_write = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_run = 1'b0; m_prev = NONE;
  endtask

  function automatic logic [31:0] m_out(input logic [7:0] c);
    logic [31:0] s;
    s = '0;
    if (c == RDATA && m_rsp.size() != 0) s = {8'h0, m_rsp[0].data};
    if (c == RID && m_rsp.size() != 0)   s = {24'h0, m_rsp[0].id};
    if (c == STATUS) begin
      s[0]     = (m_req.size() == RD);
      s[1]     = (m_req.size() == 0);
      s[2]     = (m_rsp.size() == SD);
      s[3]     = (m_rsp.size() == 0);
      s[4]     = m_ovf;
      s[5]     = m_unf;
      s[15:8]  = 8'(m_req.size());
      s[23:16] = 8'(m_rsp.size());
    end
    return s;
  endfunction

  // Compare every output against the model, advance the model over one clock edge.
  task automatic step(input string tag);
    req_t        h;
    rsp_t        r;
    logic [7:0]  c;
    logic [23:0] f;
    logic        fire, take, req_full, rsp_empty;
    #1;
    h = (m_req.size() != 0) ? m_req[0] : '0;
    take = m_run && (m_rsp.size() < SD);
    chk({tag, ".msValid"},   32'(bus.msValid),  32'(m_req.size() != 0));
    chk({tag, ".msAddress"}, bus.msAddress,     h.addr);
    chk({tag, ".msData"},    32'(bus.msData),   32'(h.data));
    chk({tag, ".msID"},      32'(bus.msID),     32'(h.id));
    chk({tag, ".msWrite"},   32'(bus.msWrite),  32'(h.wr));
    chk({tag, ".smTake"},    32'(bus.smTake),   32'(take));
    chk({tag, ".out"},       host_out,          m_out(host_in[31:24]));

    c = host_in[31:24];
    f = host_in[23:0];
    fire = (c != m_prev) && (c != NONE);
    req_full = (m_req.size() == RD);
    rsp_empty = (m_rsp.size() == 0);
    if (m_req.size() != 0 && bus.msTaken) h = m_req.pop_front();
    if (fire) begin
      case (c)
        ADDRL: m_addr[23:0] = f;
        ADDRU: m_addr[31:24] = f[7:0];
        DATA:  m_data = f;
        MID:   m_id = f[7:0];
        WRITE: m_write = f[0];
        PUSH: begin
          if (req_full) m_ovf = 1'b1;
          else begin
            m_req.push_back({m_addr, m_data, m_id, m_write});
`ifdef MEMORY_MASTER_AUTO_INC_EN
            m_addr = m_addr + 32'd1;
`endif
          end
        end
        POP: begin
          if (rsp_empty) m_unf = 1'b1;
          else r = m_rsp.pop_front();
        end
        CLR: begin m_ovf = 1'b0; m_unf = 1'b0; end
        default: ;
      endcase
    end
    if (bus.smValid && take) m_rsp.push_back({bus.smData, bus.smID});
    m_prev = c;
    m_run = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] field;
    logic        taken;
    logic        smv;
    logic [23:0] smd;
    logic [7:0]  smi;
    logic [3:0]  chkm;
    logic [31:0] exp_out;
    logic        exp_msv;
    logic [31:0] exp_addr;
    logic        exp_take;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] cmd, input logic [23:0] field, input logic taken,
                              input logic smv, input logic [23:0] smd, input logic [7:0] smi,
                              input logic [3:0] chkm, input logic [31:0] eo, input logic emsv,
                              input logic [31:0] eaddr, input logic etake);
    vecs.push_back('{cmd, field, taken, smv, smd, smi, chkm, eo, emsv, eaddr, etake});
  endfunction

  initial begin
    bus.msTaken = 1'b0;
    bus.smValid = 1'b0;
    bus.smData  = '0;
    bus.smID    = '0;
    host_in     = {STATUS, 24'h0};
    reset       = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    #1;
    chk("rst.msValid", 32'(bus.msValid), 32'd0);
    chk("rst.smTake", 32'(bus.smTake), 32'd0);
    chk("rst.status", host_out, 32'h0000_000A);
    host_in = {NONE, 24'h0};
    reset = 1'b1;
    model_reset();
    #1;
    chk("rel.smTake_first", 32'(bus.smTake), 32'd0);
    step("rel0");
    chk("rel.smTake_second", 32'(bus.smTake), 32'd1);
    step("rel1");

    // Write then read.
    add(ADDRL, 24'h345678, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(ADDRU, 24'h000012, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(DATA,  24'hABCDEF, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(MID,   24'h000005, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(WRITE, 24'h000001, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(PUSH,  24'h0, 1, 0, 0, 0, C_MSV, 0, 0, 0, 0);
    add(NONE,  24'h0, 1, 0, 0, 0, C_MSV | C_ADDR, 0, 1, 32'h1234_5678, 0);
    add(WRITE, 24'h0, 1, 0, 0, 0, C_MSV, 0, 0, 0, 0);
    add(PUSH,  24'h0, 1, 0, 0, 0, C_MSV, 0, 0, 0, 0);
    add(NONE,  24'h0, 1, 1, 24'h000042, 8'd5, C_MSV | C_TAKE, 0, 1, 0, 1);
    add(RDATA, 24'h0, 1, 0, 0, 0, C_OUT, 32'h42, 0, 0, 0);
    add(RID,   24'h0, 1, 0, 0, 0, C_OUT, 32'h5, 0, 0, 0);
    add(POP,   24'h0, 1, 0, 0, 0, C_OUT, 32'h0, 0, 0, 0);
    add(STATUS, 24'h0, 1, 0, 0, 0, C_OUT, 32'h0A, 0, 0, 0);
    // Overflow with the slave stalled.
    for (int i = 0; i < 4; i++) begin
      add(PUSH, 24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(NONE, 24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    add(PUSH,   24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h419, 0, 0, 0);
    add(CLR,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h409, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(NONE, 24'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(STATUS, 24'h0, 1, 0, 0, 0, C_OUT, 32'h0A, 0, 0, 0);
    // Underflow, then POP racing the first capture.
    add(POP,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h2A, 0, 0, 0);
    add(POP,    24'h0, 0, 1, 24'h7, 8'd1, C_TAKE, 0, 0, 0, 1);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h1_0022, 0, 0, 0);
    add(CLR,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(RDATA,  24'h0, 0, 0, 0, 0, C_OUT, 32'h7, 0, 0, 0);
    add(POP,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h0A, 0, 0, 0);
    // Response backpressure.
    for (int i = 1; i <= 4; i++) add(NONE, 24'h0, 0, 1, 24'(i), 8'd2, C_TAKE, 0, 0, 0, 1);
    add(STATUS, 24'h0, 0, 1, 24'h9, 8'd2, C_OUT | C_TAKE, 32'h4_0006, 0, 0, 0);
    add(POP,    24'h0, 0, 0, 0, 0, C_OUT | C_TAKE, 32'h0, 0, 0, 0);
    add(NONE,   24'h0, 0, 0, 0, 0, C_TAKE, 0, 0, 0, 1);
    add(RDATA,  24'h0, 0, 0, 0, 0, C_OUT, 32'h2, 0, 0, 0);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h3_0002, 0, 0, 0);
    add(POP,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(NONE,   24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(POP,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(RDATA,  24'h0, 0, 0, 0, 0, C_OUT, 32'h4, 0, 0, 0);
    add(POP,    24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(STATUS, 24'h0, 0, 0, 0, 0, C_OUT, 32'h0A, 0, 0, 0);
    // Address wrap across two pushes.
    add(ADDRL, 24'hFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(ADDRU, 24'h0000FF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(PUSH,  24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(NONE,  24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(PUSH,  24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(NONE,  24'h0, 0, 0, 0, 0, C_MSV | C_ADDR, 0, 1, 32'hFFFF_FFFF, 0);
    add(NONE,  24'h0, 1, 0, 0, 0, C_MSV | C_ADDR, 0, 1, 32'hFFFF_FFFF, 0);
    add(NONE,  24'h0, 1, 0, 0, 0, C_MSV | C_ADDR, 0, 1, SECOND_ADDR, 0);
    add(NONE,  24'h0, 1, 0, 0, 0, C_MSV, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      host_in     = {vecs[i].cmd, vecs[i].field};
      bus.msTaken = vecs[i].taken;
      bus.smValid = vecs[i].smv;
      bus.smData  = vecs[i].smd;
      bus.smID    = vecs[i].smi;
      #1;
      if (vecs[i].chkm[0]) chk($sformatf("vec%0d.out", i), host_out, vecs[i].exp_out);
      if (vecs[i].chkm[1])
        chk($sformatf("vec%0d.msValid", i), 32'(bus.msValid), 32'(vecs[i].exp_msv));
      if (vecs[i].chkm[2]) chk($sformatf("vec%0d.msAddress", i), bus.msAddress, vecs[i].exp_addr);
      if (vecs[i].chkm[3])
        chk($sformatf("vec%0d.smTake", i), 32'(bus.smTake), 32'(vecs[i].exp_take));
      step($sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle with a request outstanding.
    bus.msTaken = 1'b0;
    bus.smValid = 1'b0;
    host_in = {ADDRL, 24'h000055};
    step("mid.addr");
    host_in = {PUSH, 24'h0};
    step("mid.push");
    host_in = {NONE, 24'h0};
    step("mid.idle");
    chk("mid.pre.msValid", 32'(bus.msValid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.msValid", 32'(bus.msValid), 32'd0);
    chk("mid.msAddress", bus.msAddress, 32'd0);
    chk("mid.msData", 32'(bus.msData), 32'd0);
    chk("mid.msWrite", 32'(bus.msWrite), 32'd0);
    chk("mid.smTake", 32'(bus.smTake), 32'd0);
    chk("mid.out", host_out, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    step("mid.rel0");
    host_in = {STATUS, 24'h0};
    step("mid.rel1");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      host_in     = {(r > 11) ? NONE : 8'(r), 24'($urandom)};
      bus.msTaken = 1'($urandom_range(0, 1));
      bus.smValid = 1'($urandom_range(0, 1));
      bus.smData  = 24'($urandom);
      bus.smID    = 8'($urandom);
      step($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
